// File: rtl/pc_call_stack_pkg.sv
// Shared defaults, command priority and error-tracker encoding for the PC stage
// and the future control unit.
package pc_call_stack_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Listed from highest to lowest priority: ret > call > load > inc.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INC  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_CALL = 3'd3,
    CMD_RET  = 3'd4
  } cmd_e;

  localparam logic [0:0] ERR_CLEAN = 1'b0;
  localparam logic [0:0] ERR_SET   = 1'b1;

  function automatic cmd_e decode_cmd(input logic ret, input logic call,
                                       input logic load, input logic inc);
    if (ret)       return CMD_RET;
    else if (call) return CMD_CALL;
    else if (load) return CMD_LOAD;
    else if (inc)  return CMD_INC;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_call_stack_lifo.sv
// Return-address LIFO. Pointer saturates at 0 and DEPTH; illegal push/pop are
// ignored here and reported as errors by the parent.
module pc_call_stack_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [AW-1:0]    top_idx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  // When full the low bits of sp are 0, so sp-1 still lands on the last entry.
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign rdata_o = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)      sp_d = sp_q + SPW'(1);
    else if (pop_i && !empty_o) sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[sp_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with call/return stack and sticky overflow/underflow flags.
// Error tracker per flag: CLEAN | no error seen ; ERR | violation seen, held until clr_err.
module pc_call_stack
  import pc_call_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_in_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] pc_out_o,
  output logic             stk_full_o,
  output logic             stk_empty_o,
  output logic             ovf_o,
  output logic             unf_o
);
  cmd_e             cmd;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, stk_rdata;
  logic             push, pop, ovf_set, unf_set;
  logic [0:0]       ovf_st_q, ovf_st_d, unf_st_q, unf_st_d;

  assign cmd     = decode_cmd(ret_i, call_i, load_i, inc_i);
  assign pc_inc  = pc_q + WIDTH'(1);
  assign push    = en_i && (cmd == CMD_CALL);
  assign pop     = en_i && (cmd == CMD_RET);
  assign ovf_set = push && stk_full_o;
  assign unf_set = pop && stk_empty_o;

  pc_call_stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pc_inc),
    .rdata_o (stk_rdata),
    .full_o  (stk_full_o),
    .empty_o (stk_empty_o)
  );

  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      case (cmd)
        CMD_RET:  if (!stk_empty_o) pc_d = stk_rdata;
        CMD_CALL: pc_d = d_in_i;
        CMD_LOAD: pc_d = d_in_i;
        CMD_INC:  pc_d = pc_inc;
        default:  pc_d = pc_q;
      endcase
    end
  end

  // A new violation in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_st_d = ovf_st_q;
    unf_st_d = unf_st_q;
    if (en_i) begin
      if (ovf_set)        ovf_st_d = ERR_SET;
      else if (clr_err_i) ovf_st_d = ERR_CLEAN;
      if (unf_set)        unf_st_d = ERR_SET;
      else if (clr_err_i) unf_st_d = ERR_CLEAN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      ovf_st_q <= ERR_CLEAN;
      unf_st_q <= ERR_CLEAN;
    end else begin
      pc_q     <= pc_d;
      ovf_st_q <= ovf_st_d;
      unf_st_q <= unf_st_d;
    end
  end

  assign pc_out_o = pc_q;
  assign ovf_o    = (ovf_st_q == ERR_SET);
  assign unf_o    = (unf_st_q == ERR_SET);

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack with hand-computed expectations.
module tb_pc_call_stack;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, inc, call, ret, clr_err;
  logic [3:0] d_in;
  logic [3:0] pc;
  logic       full, empty, ovf, unf;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  pc_call_stack dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .d_in_i      (d_in),
    .load_i      (load),
    .inc_i       (inc),
    .call_i      (call),
    .ret_i       (ret),
    .clr_err_i   (clr_err),
    .pc_out_o    (pc),
    .stk_full_o  (full),
    .stk_empty_o (empty),
    .ovf_o       (ovf),
    .unf_o       (unf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one command for one clock edge, then sample 1ns after it.
  task automatic step(input logic e, input logic l, input logic i, input logic c,
                      input logic r, input logic ce, input logic [3:0] d);
    en = e; load = l; inc = i; call = c; ret = r; clr_err = ce; d_in = d;
    @(posedge clk);
    #1;
    en = 1'b1; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0;
    ret = 1'b0; clr_err = 1'b0; d_in = 4'd0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-count
    repeat (3) step(1, 0, 1, 0, 0, 0, 0);
    chk("pre_rst_pc", pc, 3);
    rst_n = 1'b0; #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_empty", empty, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 1; k <= 17; k++) begin
      step(1, 0, 1, 0, 0, 0, 0);
      chk($sformatf("inc_%0d", k), pc, k % 16);
    end

    // Load and enable hold
    step(1, 1, 0, 0, 0, 0, 4'd3);
    chk("load3", pc, 3);
    step(1, 1, 0, 0, 0, 0, 4'b1010);
    chk("load10", pc, 10);
    step(0, 1, 1, 0, 0, 0, 4'd5);
    chk("en0_hold", pc, 10);
    step(1, 0, 0, 0, 0, 0, 4'd5);
    chk("idle_hold", pc, 10);

    // Nested call/return
    step(1, 1, 0, 0, 0, 0, 4'd2);
    step(1, 0, 0, 1, 0, 0, 4'd8);
    chk("call1_pc", pc, 8);
    chk("call1_empty", empty, 0);
    step(1, 0, 0, 1, 0, 0, 4'd12);
    chk("call2_pc", pc, 12);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("ret1_pc", pc, 9);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("ret2_pc", pc, 3);
    chk("ret2_empty", empty, 1);

    // Overflow
    step(1, 1, 0, 0, 0, 0, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 1, 0, 0, 4'(k));
      chk($sformatf("fill_pc_%0d", k), pc, k);
      chk($sformatf("fill_full_%0d", k), full, (k == 4) ? 1 : 0);
    end
    step(1, 0, 0, 1, 0, 0, 4'd7);
    chk("ovf_pc", pc, 7);
    chk("ovf_flag", ovf, 1);
    chk("ovf_full", full, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_en0_clr_ignored", ovf, 1);
    for (int k = 4; k >= 1; k--) begin
      step(1, 0, 0, 0, 1, 0, 0);
      chk($sformatf("drain_pc_%0d", k), pc, k);
    end
    chk("drain_empty", empty, 1);
    chk("drain_unf", unf, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("ovf_clr", ovf, 0);

    // Underflow and clear
    step(1, 0, 0, 0, 1, 0, 0);
    chk("unf_pc_hold", pc, 1);
    chk("unf_flag", unf, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("unf_clr", unf, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("unf_set_wins", unf, 1);
    chk("unf_set_wins_pc", pc, 1);
    step(1, 0, 0, 0, 0, 1, 0);

    // Priority and wrapped push value
    step(1, 1, 0, 0, 0, 0, 4'd15);
    step(1, 0, 1, 1, 0, 0, 4'd5);
    chk("prio_call_pc", pc, 5);
    chk("prio_call_empty", empty, 0);
    step(1, 1, 0, 1, 1, 0, 4'd9);
    chk("prio_ret_pc", pc, 0);
    chk("prio_ret_empty", empty, 1);
    chk("prio_ret_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
